// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the telemetry binary-to-BCD scheduler.
package telemetry_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Largest value representable in nd decimal digits.
  function automatic int unsigned max_display(input int unsigned nd);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < nd; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift in one bit.
module bcd_shift_step
  import telemetry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] acc_i,
  input  logic                           bit_i,
  output logic [NUM_DIGITS*NIBBLE_W-1:0] shifted_c
);

  localparam int unsigned BCD_W = NUM_DIGITS * NIBBLE_W;

  logic [BCD_W-1:0] adj_c;

  always_comb begin
    adj_c = acc_i;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (acc_i[d*NIBBLE_W +: NIBBLE_W] >= NIBBLE_W'(5)) begin
        adj_c[d*NIBBLE_W +: NIBBLE_W] = acc_i[d*NIBBLE_W +: NIBBLE_W] + NIBBLE_W'(3);
      end
    end
    shifted_c = {adj_c[BCD_W-2:0], bit_i};
  end

endmodule

// File: rtl/telemetry_digit_scheduler.sv
// Per-frame snapshot of telemetry values, serially converted to BCD on one shared
// shifter and committed to the display buffer atomically.
module telemetry_digit_scheduler
  import telemetry_pkg::*;
#(
  parameter int unsigned NUM_SIGNALS = 7,
  parameter int unsigned VALUE_WIDTH = 9,
  parameter int unsigned NUM_DIGITS  = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     frame_start,
  input  logic [NUM_SIGNALS*VALUE_WIDTH-1:0]       sig_in,
  output logic [NUM_SIGNALS*NUM_DIGITS*NIBBLE_W-1:0] digits_out,
  output logic                                     busy,
  output logic                                     update_done
);

  localparam int unsigned BCD_W     = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned IDX_W     = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
  localparam int unsigned CNT_W     = $clog2(VALUE_WIDTH + 1);
  localparam int unsigned MAX_DISP  = max_display(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SIGNALS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_WIDTH - 1);

  state_e                              state_q, state_d;
  logic                                pend_q, pend_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0]              shreg_q, shreg_d;
  logic [BCD_W-1:0]                    acc_q, acc_d;
  logic                                clamp_q, clamp_d;
  logic [NUM_SIGNALS*VALUE_WIDTH-1:0]  snap_q, snap_d;
  logic [NUM_SIGNALS*BCD_W-1:0]        work_q, work_d;
  logic [NUM_SIGNALS*BCD_W-1:0]        digits_q, digits_d;
  logic                                busy_q, done_q;

  logic [VALUE_WIDTH-1:0]              cur_c;
  logic [BCD_W-1:0]                    res_c;
  logic [BCD_W-1:0]                    step_c;

  bcd_shift_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
    .acc_i     (acc_q),
    .bit_i     (shreg_q[VALUE_WIDTH-1]),
    .shifted_c (step_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    clamp_d  = clamp_q;
    snap_d   = snap_q;
    work_d   = work_q;
    digits_d = digits_q;

    cur_c = snap_q[int'(idx_q)*VALUE_WIDTH +: VALUE_WIDTH];
    // Accumulator holds the MSD in its top nibble; the buffer holds digit 0 lowest.
    res_c = '0;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      res_c[d*NIBBLE_W +: NIBBLE_W] = acc_q[(int'(NUM_DIGITS)-1-d)*NIBBLE_W +: NIBBLE_W];
    end

    if (frame_start && (state_q != ST_IDLE)) pend_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start || pend_q) begin
          snap_d  = sig_in;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        acc_d   = '0;
        clamp_d = (32'(cur_c) > MAX_DISP);
        shreg_d = clamp_d ? '0 : cur_c;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d   = step_c;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = ST_STORE;
      end
      ST_STORE: begin
        work_d[int'(idx_q)*BCD_W +: BCD_W] = clamp_q ? {NUM_DIGITS{4'h9}} : res_c;
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        digits_d = work_q;
        if (pend_q) begin
          pend_d  = 1'b0;
          snap_d  = sig_in;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      acc_q    <= '0;
      clamp_q  <= 1'b0;
      snap_q   <= '0;
      work_q   <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      clamp_q  <= clamp_d;
      snap_q   <= snap_d;
      work_q   <= work_d;
      digits_q <= digits_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_q == ST_COMMIT);
    end
  end

  assign digits_out  = digits_q;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_telemetry_digit_scheduler.sv
// Directed bench for telemetry_digit_scheduler: table-driven sweeps plus corner sequences.
module tb_telemetry_digit_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [62:0] sig_in;
  logic [83:0] digits_out;
  logic        busy;
  logic        update_done;

  logic [69:0] sig_c;
  logic [83:0] digits_c;
  logic        busy_c;
  logic        done_c;

  int total = 0;
  int bad   = 0;

  telemetry_digit_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .sig_in      (sig_in),
    .digits_out  (digits_out),
    .busy        (busy),
    .update_done (update_done)
  );

  telemetry_digit_scheduler #(.NUM_SIGNALS(7), .VALUE_WIDTH(10), .NUM_DIGITS(3)) dut_c (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .sig_in      (sig_c),
    .digits_out  (digits_c),
    .busy        (busy_c),
    .update_done (done_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0][8:0]  val;
    logic [6:0][11:0] exp;
  } vec_t;

  vec_t vecs [3];

  // Row as stored in digits_out: digit 0 (MSD) in the lowest nibble.
  function automatic logic [11:0] row(input int d0, input int d1, input int d2);
    return {4'(d2), 4'(d1), 4'(d0)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; the next edge is the sample edge E0.
  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit moved);
    logic [83:0] prev;
    prev  = digits_out;
    n     = 0;
    moved = 1'b0;
    while (!update_done && n < 300) begin
      tick();
      n++;
      if (!update_done && digits_out != prev) moved = 1'b1;
    end
  endtask

  function automatic int rowof(input logic [83:0] d, input int s);
    return int'(d[s*12 +: 12]);
  endfunction

  initial begin
    int  n;
    bit  moved;
    int  p1, p2, pc;

    vecs[0].val = {9'd100, 9'd42, 9'd42, 9'd0, 9'd42, 9'd42, 9'd511};
    vecs[0].exp = {row(1,0,0), row(0,4,2), row(0,4,2), row(0,0,0),
                   row(0,4,2), row(0,4,2), row(5,1,1)};
    vecs[1].val = {9'd500, 9'd256, 9'd255, 9'd99, 9'd10, 9'd9, 9'd1};
    vecs[1].exp = {row(5,0,0), row(2,5,6), row(2,5,5), row(0,9,9),
                   row(0,1,0), row(0,0,9), row(0,0,1)};
    vecs[2].val = {9'd509, 9'd128, 9'd64, 9'd7, 9'd0, 9'd321, 9'd123};
    vecs[2].exp = {row(5,0,9), row(1,2,8), row(0,6,4), row(0,0,7),
                   row(0,0,0), row(3,2,1), row(1,2,3)};

    // Reset with nonzero inputs
    reset       = 1'b0;
    frame_start = 1'b0;
    sig_in      = {7{9'd77}};
    sig_c       = {7{10'd77}};
    repeat (5) tick();
    chk("rst_digits_zero", int'(digits_out != '0), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(update_done), 0);
    reset = 1'b1;
    pc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (update_done || busy || digits_out != '0) pc++;
    end
    chk("idle_no_activity", pc, 0);

    // Table-driven full sweeps
    for (int v = 0; v < 3; v++) begin
      sig_in = vecs[v].val;
      chk($sformatf("v%0d_busy_before", v), int'(busy), 0);
      pulse();
      chk($sformatf("v%0d_busy_rise", v), int'(busy), 1);
      wait_done(n, moved);
      chk($sformatf("v%0d_latency", v), n, 78);
      chk($sformatf("v%0d_stable", v), int'(moved), 0);
      chk($sformatf("v%0d_busy_idle", v), int'(busy), 0);
      for (int s = 0; s < 7; s++) begin
        chk($sformatf("v%0d_row%0d", v, s), rowof(digits_out, s), int'(vecs[v].exp[s]));
      end
      tick();
      chk($sformatf("v%0d_done_width", v), int'(update_done), 0);
    end

    // Snapshot: input change mid-sweep is ignored
    sig_in[2*9 +: 9] = 9'd7;
    pulse();
    repeat (10) tick();
    sig_in[2*9 +: 9] = 9'd300;
    wait_done(n, moved);
    chk("snap_row2_old", rowof(digits_out, 2), int'(row(0,0,7)));
    tick();
    pulse();
    wait_done(n, moved);
    chk("snap_latency2", n, 78);
    chk("snap_row2_new", rowof(digits_out, 2), int'(row(3,0,0)));
    tick();

    // Pending: extra pulses during a sweep queue exactly one more sweep
    pulse();
    p1 = -1; p2 = -1; pc = 0; n = 0;
    for (int k = 1; k <= 200; k++) begin
      frame_start = (n == 20 || n == 40);
      tick();
      n = k;
      frame_start = 1'b0;
      if (update_done) begin
        pc++;
        if (p1 < 0) p1 = n; else if (p2 < 0) p2 = n;
      end
      if (n == 78) chk("pend_busy_at_commit", int'(busy), 1);
    end
    chk("pend_count", pc, 2);
    chk("pend_first", p1, 78);
    chk("pend_second", p2, 156);
    chk("pend_idle_after", int'(busy), 0);

    // Reset mid-sweep aborts immediately
    sig_in = vecs[1].val;
    pulse();
    repeat (30) tick();
    chk("mid_pre_digits_nonzero", int'(digits_out != '0), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_digits", int'(digits_out != '0), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(update_done), 0);
    repeat (2) tick();
    reset = 1'b1;
    pc = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (update_done || busy) pc++;
    end
    chk("mid_no_resume", pc, 0);
    chk("mid_digits_stay_zero", int'(digits_out != '0), 0);

    // Clamp on the 10-bit instance
    sig_c = {10'd5, 10'd512, 10'd0, 10'd998, 10'd1000, 10'd1023, 10'd999};
    pulse();
    n = 0;
    while (!done_c && n < 300) begin
      tick();
      n++;
    end
    chk("clamp_latency", n, 85);
    chk("clamp_row0", rowof(digits_c, 0), int'(row(9,9,9)));
    chk("clamp_row1", rowof(digits_c, 1), int'(row(9,9,9)));
    chk("clamp_row2", rowof(digits_c, 2), int'(row(9,9,9)));
    chk("clamp_row3", rowof(digits_c, 3), int'(row(9,9,8)));
    chk("clamp_row4", rowof(digits_c, 4), int'(row(0,0,0)));
    chk("clamp_row5", rowof(digits_c, 5), int'(row(5,1,2)));
    chk("clamp_row6", rowof(digits_c, 6), int'(row(0,0,5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
